// File: rtl/program_sequencer_if.sv
// Program sequencer bus: load port, processor handshake, status.
// Master drives loads/handshake; slave is the sequencer.
interface program_sequencer_if;
  logic       LOAD;
  logic [9:0] LD_DATA;
  logic       START;
  logic       BUS_TAKE;
  logic       DONE;
  logic [9:0] OUT_DATA_BUS;
  logic       STEP;
  logic [3:0] PC;
  logic [4:0] COUNT;
  logic       BUSY;
  logic       FINISHED;
  logic       ERR;

  modport master (
    output LOAD, LD_DATA, START,
    output BUS_TAKE, DONE,
    input  OUT_DATA_BUS, STEP, PC, COUNT,
    input  BUSY, FINISHED, ERR
  );

  modport slave (
    input  LOAD, LD_DATA, START,
    input  BUS_TAKE, DONE,
    output OUT_DATA_BUS, STEP, PC, COUNT,
    output BUSY, FINISHED, ERR
  );
endinterface

// File: rtl/program_sequencer.sv
// Program sequencer: stores up to 16 words and replays them
// to a processor input bus, one settled word per STEP pulse.
module program_sequencer #(
  parameter int SETTLE = 2,
  parameter int WDOG   = 8
) (
  input logic CLK50MHz,
  input logic CLR,
  program_sequencer_if.slave bus
);

  localparam int WW = (WDOG < 2) ? 1 : $clog2(WDOG + 1);
  localparam logic [2:0]    ST_LAST = 3'(SETTLE - 1);
  localparam logic [WW-1:0] WD_LAST = WW'(WDOG - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STEP, S_FIN, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    pc_q, pc_d;
  logic [4:0]    count_q, count_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [2:0]    st_q, st_d;
  logic          bt_q, bt_d;
  logic          dn_q, dn_d;
  logic [9:0]    out_q, out_d;
  logic          we;
  logic          pc_lt;
  logic          pc_eq;

  logic [9:0] mem_q [16];

  // pc is 5 bits so it can sit at COUNT=16; PC shows the low 4.
  assign pc_lt = pc_q < count_q;
  assign pc_eq = pc_q == count_q;

  // Program store; survives CLR, and CLR blocks writes.
  always_ff @(posedge CLK50MHz) begin
    if (we && !CLR) mem_q[count_q[3:0]] <= bus.LD_DATA;
  end

  // Next-state, counters and the word presented on the bus.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    wd_d    = wd_q;
    st_d    = st_q;
    bt_d    = bt_q;
    dn_d    = dn_q;
    we      = 1'b0;
    out_d   = '0;
    unique case (state_q)
      S_IDLE, S_FIN: begin
        if (bus.LOAD) begin
          if (!count_q[4]) begin
            we      = 1'b1;
            count_d = count_q + 5'd1;
          end
        end else if (bus.START) begin
          pc_d    = '0;
          wd_d    = '0;
          st_d    = '0;
          state_d = (count_q == 5'd0) ? S_FIN : S_SETUP;
        end
      end
      S_SETUP: begin
        if (st_q == ST_LAST) begin
          bt_d = bus.BUS_TAKE;
          dn_d = bus.DONE;
          if (bus.BUS_TAKE && pc_eq) state_d = S_ERR;
          else                       state_d = S_STEP;
        end else begin
          st_d = st_q + 3'd1;
        end
      end
      S_STEP: begin
        st_d = '0;
        if (bt_q) begin
          pc_d    = pc_q + 5'd1;
          wd_d    = '0;
          state_d = S_SETUP;
        end else if (pc_eq && dn_q) begin
          state_d = S_FIN;
        end else begin
          wd_d    = wd_q + 1'b1;
          state_d = (wd_q == WD_LAST) ? S_ERR : S_SETUP;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if ((state_d == S_SETUP || state_d == S_STEP)
        && pc_d < count_q)
      out_d = mem_q[pc_d[3:0]];
  end

  // State and counter registers with synchronous clear.
  always_ff @(posedge CLK50MHz) begin
    if (CLR) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      count_q <= '0;
      wd_q    <= '0;
      st_q    <= '0;
      bt_q    <= 1'b0;
      dn_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      wd_q    <= wd_d;
      st_q    <= st_d;
      bt_q    <= bt_d;
      dn_q    <= dn_d;
      out_q   <= out_d;
    end
  end

  assign bus.OUT_DATA_BUS = out_q;
  assign bus.STEP         = state_q == S_STEP;
  assign bus.PC           = pc_q[3:0];
  assign bus.COUNT        = count_q;
  assign bus.BUSY         = state_q == S_SETUP
                         || state_q == S_STEP;
  assign bus.FINISHED     = state_q == S_FIN;
  assign bus.ERR          = state_q == S_ERR;

  logic unused;
  assign unused = pc_lt;

endmodule

// File: tb/tb_program_sequencer.sv
// Testbench for program_sequencer: scoreboard of presented
// words per STEP plus status checks after each scenario.
module tb_program_sequencer;

  localparam int WDOG = 8;

  logic clk;
  logic clr;
  program_sequencer_if sq();

  program_sequencer dut (
    .CLK50MHz (clk),
    .CLR      (clr),
    .bus      (sq.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] q[$];
  logic [9:0] mmem [16];
  int mcount   = 0;
  int run_steps = 0;
  int take_lim  = 0;
  logic [9:0] p1 = '0;
  logic [9:0] p2 = '0;

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // STEP monitor: pop expected word, check it was held.
  always @(negedge clk) begin
    if (sq.STEP === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_step", 32'd1, 32'd0);
      end else begin
        logic [9:0] w;
        w = q.pop_front();
        check("word", 32'(sq.OUT_DATA_BUS), 32'(w));
      end
      check("hold", 32'(p1 == sq.OUT_DATA_BUS
                       && p2 == sq.OUT_DATA_BUS), 32'd1);
      run_steps++;
      sq.BUS_TAKE = run_steps < take_lim;
    end
    p2 = p1;
    p1 = sq.OUT_DATA_BUS;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    mcount = 0;
  endtask

  task automatic load(logic [9:0] w);
    sq.LOAD = 1'b1;
    sq.LD_DATA = w;
    tick();
    sq.LOAD = 1'b0;
    if (mcount < 16) begin
      mmem[mcount] = w;
      mcount++;
    end
  endtask

  task automatic pulse_start();
    sq.START = 1'b1;
    tick();
    sq.START = 1'b0;
  endtask

  task automatic check_zero(string tag);
    check({tag, "_out"},  32'(sq.OUT_DATA_BUS), 32'd0);
    check({tag, "_step"}, 32'(sq.STEP), 32'd0);
    check({tag, "_pc"},   32'(sq.PC), 32'd0);
    check({tag, "_cnt"},  32'(sq.COUNT), 32'd0);
    check({tag, "_busy"}, 32'(sq.BUSY), 32'd0);
    check({tag, "_fin"},  32'(sq.FINISHED), 32'd0);
    check({tag, "_err"},  32'(sq.ERR), 32'd0);
  endtask

  // Model the run, push expected words, then run the DUT.
  task automatic run(string tag, int take_n, bit dn);
    int pc, wd, n, cyc;
    bit fin, err, bt;
    pc = 0; wd = 0; n = 0; fin = 0; err = 0;
    for (int i = 0; i < 100; i++) begin
      bt = n < take_n;
      if (bt && pc == mcount) begin err = 1; break; end
      q.push_back(pc < mcount ? mmem[pc] : 10'd0);
      n++;
      if (bt) begin
        pc++;
        wd = 0;
      end else if (pc == mcount && dn) begin
        fin = 1;
        break;
      end else begin
        wd++;
        if (wd == WDOG) begin err = 1; break; end
      end
    end
    take_lim = take_n;
    run_steps = 0;
    sq.BUS_TAKE = take_n > 0;
    sq.DONE = dn;
    pulse_start();
    cyc = 0;
    while (!(sq.FINISHED || sq.ERR) && cyc < 400) begin
      tick();
      cyc++;
    end
    if (cyc >= 400) check({tag, "_timeout"}, 32'd1, 32'd0);
    check({tag, "_fin"},   32'(sq.FINISHED), 32'(fin));
    check({tag, "_err"},   32'(sq.ERR), 32'(err));
    check({tag, "_pc"},    32'(sq.PC), 32'(4'(pc)));
    check({tag, "_steps"}, 32'(run_steps), 32'(n));
    check({tag, "_sb"},    32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    int s;
    clr = 1'b1;
    sq.LOAD = 1'b0;
    sq.LD_DATA = '0;
    sq.START = 1'b0;
    sq.BUS_TAKE = 1'b0;
    sq.DONE = 1'b0;
    tick();
    tick();
    clr = 1'b0;
    check_zero("reset");

    // Empty program: START goes straight to FIN.
    pulse_start();
    check("empty_fin",  32'(sq.FINISHED), 32'd1);
    check("empty_out",  32'(sq.OUT_DATA_BUS), 32'd0);
    check("empty_busy", 32'(sq.BUSY), 32'd0);

    // Two words, taken on both steps, then DONE.
    load(10'h041);
    load(10'h2A5);
    check("two_cnt", 32'(sq.COUNT), 32'd2);
    run("two", 2, 1'b1);
    run("replay", 2, 1'b1);

    // CLR, then LOAD and START together: LOAD wins.
    do_clr();
    check_zero("clr1");
    sq.LOAD = 1'b1;
    sq.START = 1'b1;
    sq.LD_DATA = 10'h1C3;
    tick();
    sq.LOAD = 1'b0;
    sq.START = 1'b0;
    mmem[0] = 10'h1C3;
    mcount = 1;
    check("prio_cnt",  32'(sq.COUNT), 32'd1);
    check("prio_busy", 32'(sq.BUSY), 32'd0);

    // Underrun: BUS_TAKE held high past the last word.
    run("under", 99, 1'b0);
    s = run_steps;
    pulse_start();
    repeat (10) tick();
    check("errhold_err",   32'(sq.ERR), 32'd1);
    check("errhold_steps", 32'(run_steps), 32'(s));

    // Watchdog: never taken, never done.
    do_clr();
    load(10'h155);
    run("wdog", 0, 1'b0);

    // CLR on the SETUP cycle right before a STEP.
    do_clr();
    load(10'h0AA);
    load(10'h333);
    take_lim = 0;
    sq.BUS_TAKE = 1'b0;
    sq.DONE = 1'b0;
    pulse_start();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    mcount = 0;
    check_zero("abort");
    tick();
    check("abort_step2", 32'(sq.STEP), 32'd0);

    // Full memory; the 17th load must not land anywhere.
    for (int i = 0; i < 16; i++) load(10'(i * 37 + 1));
    sq.LOAD = 1'b1;
    sq.LD_DATA = 10'h3FF;
    tick();
    sq.LOAD = 1'b0;
    check("full_cnt", 32'(sq.COUNT), 32'd16);
    run("full", 16, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have ports: CLK50MHz  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have: CLR  in  1  synchronous active-high reset.
REQ-004 SHALL have: LOAD  in  1  one-cycle pulse, write LD_DATA into program memory.
REQ-005 SHALL have: LD_DATA  in  10  instruction/immediate word to store.
REQ-006 SHALL have: START  in  1  one-cycle pulse, begin or replay program.
REQ-007 SHALL have: BUS_TAKE  in  1  high when processor latches its input bus on next step (IRin or Ext).
REQ-008 SHALL have: DONE  in  1  processor end-of-instruction flag (counter clear).
REQ-009 SHALL have: OUT_DATA_BUS  out  10  word driven to processor input bus, registered.
REQ-010 SHALL have: STEP  out  1  one-cycle processor clock-enable pulse.
REQ-011 SHALL have: PC  out  4  index of current word; COUNT  out  5  words loaded (0..16).
REQ-012 SHALL have: BUSY  out  1, FINISHED  out  1, ERR  out  1  status flags.
REQ-013 SHALL have parameter SETTLE, default 2, cycles word is held before each STEP (1..7).
REQ-014 SHALL have parameter WDOG, default 8, max consecutive steps with BUS_TAKE low.

Function
REQ-015 SHALL store up to 16 words in a 16x10 memory; memory is not cleared by CLR.
REQ-016 SHALL, in IDLE with LOAD=1 and COUNT<16, write mem[COUNT]=LD_DATA and increment COUNT next cycle.
REQ-017 SHALL ignore LOAD when COUNT=16 or state is not IDLE/FIN.
REQ-018 SHALL implement states IDLE, SETUP, STEP, FIN, ERR.
REQ-019 SHALL, on START in IDLE or FIN, set PC=0, clear watchdog, enter SETUP; if COUNT=0 enter FIN directly.
REQ-020 SHALL ignore START in SETUP, STEP, ERR.
REQ-021 SHALL, in SETUP, drive OUT_DATA_BUS=mem[PC] if PC<COUNT else 0, and count SETTLE cycles.
REQ-022 SHALL, at last SETUP cycle, sample BUS_TAKE and DONE, then enter STEP.
REQ-023 SHALL assert STEP for exactly one cycle in STEP state; OUT_DATA_BUS held stable through it.
REQ-024 SHALL increment PC after STEP iff sampled BUS_TAKE=1 and PC<COUNT.
REQ-025 SHALL enter ERR if sampled BUS_TAKE=1 while PC=COUNT (program underrun); no STEP issued.
REQ-026 SHALL, with PC=COUNT and sampled DONE=1, issue the final STEP then enter FIN.
REQ-027 SHALL count consecutive steps with BUS_TAKE=0; reaching WDOG enters ERR after that step.
REQ-028 SHALL reset watchdog count on any step with BUS_TAKE=1.
REQ-029 SHALL drive BUSY=1 in SETUP/STEP, FINISHED=1 in FIN, ERR=1 in ERR, all else 0.
REQ-030 SHALL leave ERR only via CLR.
REQ-031 SHALL give LOAD priority over START when both pulse in IDLE (START ignored that cycle).
REQ-032 SHALL, on CLR mid-run, abort without a STEP pulse in the following cycle.

Reset
REQ-033 SHALL, on CLR=1, set state IDLE, PC=0, COUNT=0, watchdog=0, OUT_DATA_BUS=0, STEP=0, BUSY=0, FINISHED=0, ERR=0 at next edge.
REQ-034 SHALL give CLR priority over LOAD, START and all transitions.

Verification
REQ-035 Load 10'h041,10'h2A5; START; BUS_TAKE=1 on both steps, DONE=1 after -> two words presented each for 2 cycles, 3 STEP pulses total, PC=2, FINISHED=1.
REQ-036 COUNT=0, START -> FIN next cycle, no STEP, OUT_DATA_BUS=0.
REQ-037 17 LOAD pulses of 10'h3FF -> COUNT=16, memory unchanged by 17th.
REQ-038 One word loaded, BUS_TAKE held 1 -> after first step ERR=1, PC=1, no further STEP until CLR.
REQ-039 BUS_TAKE=0, DONE=0 forever -> exactly 8 STEP pulses then ERR=1.
REQ-040 CLR during STEP-preceding SETUP cycle -> no STEP next cycle, all outputs 0, COUNT=0; replay of FIN via START reproduces same word sequence.
